xor_parity_rx: RTL and testbench
================================

# xor_parity_rx

Serial frame receiver with XOR parity checking. It is the receive end of the team's XOR-parity serial link. It deserializes start, data, parity and stop bits from a single-bit line, using a per-bit sample strobe, and folds each data bit into a running XOR parity register. Each completed frame is presented as a parallel word with a one-cycle valid pulse and parity and framing error flags.

## Interface
Parameters:
- DATA_W, 8, number of data bits per frame, LSB first; legal range 1..16.
- PARITY_ODD, 0, parity sense: 0 = even parity, 1 = odd parity.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- bit_en, input, 1, one-cycle sample strobe, one per bit period; the line is sampled only when it is high.
- rx_i, input, 1, serial line; idle high, start bit low.
- data_o, output, DATA_W, last good-framed word; holds its value between frames.
- valid_o, output, 1, one-cycle pulse when data_o is updated.
- parity_err_o, output, 1, parity result for the frame; pulses together with valid_o.
- frame_err_o, output, 1, one-cycle pulse when the stop bit is sampled low.
- busy_o, output, 1, high in every state except IDLE.

## Operation
- States:
  - IDLE: on bit_en with rx_i=0 (start bit), go to DATA; clear bit count and parity register. On bit_en with rx_i=1, stay in IDLE.
  - DATA: on each bit_en, shift rx_i into the shift register at bit [count] (LSB first), set par <= par ^ rx_i, and increment count. After the DATA_W-th bit, go to PARITY.
  - PARITY: on bit_en, latch perr = par ^ rx_i ^ PARITY_ODD, then go to STOP.
  - STOP:
    - On bit_en with rx_i=1: set data_o <= shift register, pulse valid_o, drive parity_err_o = perr, go to IDLE.
    - On bit_en with rx_i=0: pulse frame_err_o, leave data_o unchanged, no valid_o, go to WAIT_HIGH.
  - WAIT_HIGH: on bit_en with rx_i=1, go to IDLE. A held-low line (break) is never treated as a start bit.
- Frames with a parity error are still delivered: valid_o=1 together with parity_err_o=1.
- Bit counter width is clog2(DATA_W+1); it never wraps within a frame.
- rx_i and bit_en are synchronous to clk. Any rx_i change between strobes is ignored.
- Continuous bit_en=1 is legal and gives one bit per clock.

## Timing
- Reset values: data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0, state=IDLE. Reset mid-frame aborts the frame with no pulse.
- All outputs are registered.
- valid_o, parity_err_o and frame_err_o are high only in the cycle after the clk edge at which the stop bit is sampled.
- Frame length is DATA_W+3 strobes. With continuous bit_en, valid_o rises DATA_W+3 cycles after the cycle in which the start bit is sampled.
- busy_o goes high in the cycle after the start sample and goes low in the same cycle that valid_o or the STOP exit occurs. It stays high through WAIT_HIGH.
- Back-to-back frames: a start bit may be sampled on the first bit_en after STOP, with no idle gap required.
- parity_err_o is 0 in every cycle where valid_o is 0.

## Test plan
- Even parity, DATA_W=8, bit_en continuous. Frame: start 0; data bits 1,0,1,0,0,1,0,1; parity 0; stop 1. Required: data_o=0xA5, one valid_o pulse 11 cycles after the start sample, parity_err_o=0.
- Same frame with parity bit 1. Required: data_o=0xA5, valid_o=1, parity_err_o=1 in the same cycle.
- Same frame with stop bit 0 and rx_i held low for 5 further strobes. Required: one frame_err_o pulse, no valid_o, data_o keeps its previous value, busy_o stays high, and no new frame starts until rx_i returns high.
- Assert reset after 4 data bits of a 0x3C frame, then send a full 0x5A frame. Required: all outputs 0 during reset, no pulse for the aborted frame, data_o=0x5A afterwards.
- PARITY_ODD=1, bit_en every 3rd cycle, rx_i toggled in the non-strobe cycles. Frame 0x00 with parity bit 1. Required: data_o=0x00, parity_err_o=0, no effect from the toggles between strobes.
- Two back-to-back frames, 0xFF then 0x01, with even parity, no idle gap and continuous bit_en. Required: two valid_o pulses 11 cycles apart, data_o=0xFF then 0x01, both with parity_err_o=0.

Source files
------------

// File: rtl/xor_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : xor_parity_rx
// Brief    : Strobe-sampled serial frame receiver (start, DATA_W data bits
//            LSB first, XOR parity, stop) with parity and framing error flags.
// Revision : 1.0 - initial release
// ============================================================================
module xor_parity_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DATA      = 3'd1,
        S_PARITY    = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    w_shift_nxt;
    logic                 r_perr;
    logic                 w_perr_nxt;
    logic [DATA_W-1:0]    w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_perr_out_nxt;
    logic                 w_ferr_nxt;
    logic                 w_busy_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_par        <= 1'b0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_par        <= w_par_nxt;
            r_shift      <= w_shift_nxt;
            r_perr       <= w_perr_nxt;
            data_o       <= w_data_nxt;
            valid_o      <= w_valid_nxt;
            parity_err_o <= w_perr_out_nxt;
            frame_err_o  <= w_ferr_nxt;
            busy_o       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_par_nxt      = r_par;
        w_shift_nxt    = r_shift;
        w_perr_nxt     = r_perr;
        w_data_nxt     = data_o;
        w_valid_nxt    = 1'b0;
        w_perr_out_nxt = 1'b0;
        w_ferr_nxt     = 1'b0;

        if (bit_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!rx_i) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                        w_par_nxt   = 1'b0;
                    end
                end
                S_DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (r_cnt == c_CNT_W'(i)) begin
                            w_shift_nxt[i] = rx_i;
                        end
                    end
                    w_par_nxt = r_par ^ rx_i;
                    w_cnt_nxt = r_cnt + c_ONE;
                    if (r_cnt == c_LAST_BIT) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_perr_nxt  = r_par ^ rx_i ^ PARITY_ODD;
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (rx_i) begin
                        w_data_nxt     = r_shift;
                        w_valid_nxt    = 1'b1;
                        w_perr_out_nxt = r_perr;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        // Bad stop: report it, keep the last good word, wait out the break
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_i) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_xor_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_parity_rx
// Brief    : Scoreboard bench for xor_parity_rx (even and odd parity instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_parity_rx;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       busy;
        int         cyc;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_en_e = 1'b0, rx_e = 1'b1;
    logic       bit_en_odd = 1'b0, rx_odd = 1'b1;
    logic [7:0] data_e, data_odd;
    logic       valid_e, perr_e, ferr_e, busy_e;
    logic       valid_odd, perr_odd, ferr_odd, busy_odd;

    xor_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .reset(reset), .bit_en(bit_en_e), .rx_i(rx_e),
        .data_o(data_e), .valid_o(valid_e), .parity_err_o(perr_e),
        .frame_err_o(ferr_e), .busy_o(busy_e)
    );

    xor_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .reset(reset), .bit_en(bit_en_odd), .rx_i(rx_odd),
        .data_o(data_odd), .valid_o(valid_odd), .parity_err_o(perr_odd),
        .frame_err_o(ferr_odd), .busy_o(busy_odd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rec_t obs_e[$], obs_odd[$];
    int   ferr_cnt_e = 0, ferr_cnt_odd = 0, stray_perr = 0;

    always @(negedge clk) begin
        rec_t r;
        if (valid_e) begin
            r.data = data_e; r.perr = perr_e; r.busy = busy_e; r.cyc = cyc;
            obs_e.push_back(r);
        end
        if (valid_odd) begin
            r.data = data_odd; r.perr = perr_odd; r.busy = busy_odd; r.cyc = cyc;
            obs_odd.push_back(r);
        end
        if (ferr_e)   ferr_cnt_e++;
        if (ferr_odd) ferr_cnt_odd++;
        if ((perr_e && !valid_e) || (perr_odd && !valid_odd)) stray_perr++;
    end

    rec_t exp_e[$], exp_odd[$];
    int   rd_e = 0, rd_odd = 0;
    int   n_checks = 0, n_fail = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500000");
        $fatal(1, "watchdog");
    end

    task automatic drive_e(input logic en, input logic b);
        bit_en_e = en;
        rx_e     = b;
        @(posedge clk);
        #1;
    endtask

    // Continuous-strobe frame into the even instance; good-stop frames are scored
    task automatic send_e(input logic [7:0] d, input logic pbit, input logic sbit);
        int   t0;
        rec_t x;
        t0 = cyc;
        drive_e(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) drive_e(1'b1, d[i]);
        drive_e(1'b1, pbit);
        drive_e(1'b1, sbit);
        if (sbit) begin
            x.data = d; x.perr = (^d) ^ pbit; x.busy = 1'b0; x.cyc = t0 + 11;
            exp_e.push_back(x);
        end
    endtask

    // Strobe every third cycle into the odd instance, line toggled between strobes
    task automatic send_odd_sparse(input logic [7:0] d, input logic pbit);
        logic [10:0] fr;
        int          t_stop;
        rec_t        x;
        fr = {1'b1, pbit, d, 1'b0};
        t_stop = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) t_stop = cyc;
            bit_en_odd = 1'b1; rx_odd = fr[i];
            @(posedge clk); #1;
            bit_en_odd = 1'b0; rx_odd = ~fr[i];
            @(posedge clk); #1;
            rx_odd = fr[i];
            @(posedge clk); #1;
        end
        rx_odd = 1'b1;
        x.data = d; x.perr = ~((^d) ^ pbit); x.busy = 1'b0; x.cyc = t_stop + 1;
        exp_odd.push_back(x);
    endtask

    task automatic fetch(input bit odd, output rec_t x, output rec_t o, output bit tmo);
        int n;
        n = 0;
        while ((odd ? (obs_odd.size() - rd_odd) : (obs_e.size() - rd_e)) < 1 && n < 80) begin
            @(negedge clk); #1;
            n++;
        end
        tmo = (odd ? (obs_odd.size() - rd_odd) : (obs_e.size() - rd_e)) < 1;
        x = odd ? exp_odd.pop_front() : exp_e.pop_front();
        o.data = 8'hxx; o.perr = 1'bx; o.busy = 1'bx; o.cyc = -1;
        if (!tmo) begin
            if (odd) begin o = obs_odd[rd_odd]; rd_odd++; end
            else     begin o = obs_e[rd_e];     rd_e++;   end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++; if (data_e !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h want 00", data_e); end
        n_checks++; if (valid_e !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_e); end
        n_checks++; if (perr_e !== 1'b0)   begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr_e); end
        n_checks++; if (ferr_e !== 1'b0)   begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr_e); end
        n_checks++; if (busy_e !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_e); end
        n_checks++; if (data_odd !== 8'h00) begin n_fail++; $display("FAIL reset_data_odd: got %h want 00", data_odd); end
        @(posedge clk); #1;
        reset = 1'b0;
        drive_e(1'b1, 1'b1);
    endtask

    task automatic test_even_frame(input logic pbit);
        rec_t x, o;
        bit   tmo;
        send_e(8'hA5, pbit, 1'b1);
        rx_e = 1'b1;
        fetch(1'b0, x, o, tmo);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL frame_timeout: got no valid_o, want pulse"); end
        n_checks++; if (o.data !== x.data) begin n_fail++; $display("FAIL frame_data: got %h want %h", o.data, x.data); end
        n_checks++; if (o.perr !== x.perr) begin n_fail++; $display("FAIL frame_perr: got %b want %b", o.perr, x.perr); end
        n_checks++; if (o.cyc !== x.cyc)   begin n_fail++; $display("FAIL frame_latency: got cycle %0d want %0d", o.cyc, x.cyc); end
        n_checks++; if (o.busy !== 1'b0)   begin n_fail++; $display("FAIL frame_busy_at_valid: got %b want 0", o.busy); end
        repeat (3) drive_e(1'b1, 1'b1);
        n_checks++; if (obs_e.size() != rd_e) begin n_fail++; $display("FAIL frame_single_pulse: got %0d extra want 0", obs_e.size() - rd_e); end
    endtask

    task automatic test_frame_err();
        rec_t x, o;
        bit   tmo;
        int   f0;
        send_e(8'h0F, 1'b0, 1'b1);
        rx_e = 1'b1;
        fetch(1'b0, x, o, tmo);
        n_checks++; if (o.data !== x.data) begin n_fail++; $display("FAIL ferr_pre_data: got %h want %h", o.data, x.data); end
        drive_e(1'b1, 1'b1);
        f0 = ferr_cnt_e;
        send_e(8'hA5, 1'b0, 1'b0);
        n_checks++; if (busy_e !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_after_stop: got %b want 1", busy_e); end
        for (int i = 0; i < 5; i++) begin
            drive_e(1'b1, 1'b0);
            n_checks++; if (busy_e !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_held_low[%0d]: got %b want 1", i, busy_e); end
        end
        n_checks++; if (ferr_cnt_e - f0 != 1) begin n_fail++; $display("FAIL ferr_pulse_count: got %0d want 1", ferr_cnt_e - f0); end
        n_checks++; if (obs_e.size() != rd_e) begin n_fail++; $display("FAIL ferr_no_valid: got %0d pulses want 0", obs_e.size() - rd_e); end
        n_checks++; if (data_e !== 8'h0F) begin n_fail++; $display("FAIL ferr_data_hold: got %h want 0f", data_e); end
        drive_e(1'b1, 1'b1);
        n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b want 0", busy_e); end
    endtask

    task automatic test_reset_abort();
        rec_t       x, o;
        bit         tmo;
        int         f0;
        logic [7:0] d;
        d = 8'h3C;
        f0 = ferr_cnt_e;
        drive_e(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive_e(1'b1, d[i]);
        bit_en_e = 1'b0; rx_e = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++; if (data_e !== 8'h00) begin n_fail++; $display("FAIL abort_data: got %h want 00", data_e); end
        n_checks++; if (busy_e !== 1'b0)  begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_e); end
        n_checks++; if ({valid_e, perr_e, ferr_e} !== 3'b000) begin n_fail++; $display("FAIL abort_flags: got %b want 000", {valid_e, perr_e, ferr_e}); end
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (3) drive_e(1'b1, 1'b1);
        n_checks++; if (obs_e.size() != rd_e || ferr_cnt_e != f0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d valid %0d ferr want 0 0", obs_e.size() - rd_e, ferr_cnt_e - f0); end
        send_e(8'h5A, 1'b0, 1'b1);
        rx_e = 1'b1;
        fetch(1'b0, x, o, tmo);
        n_checks++; if (o.data !== 8'h5A) begin n_fail++; $display("FAIL abort_next_data: got %h want 5a", o.data); end
        n_checks++; if (o.perr !== x.perr) begin n_fail++; $display("FAIL abort_next_perr: got %b want %b", o.perr, x.perr); end
    endtask

    task automatic test_odd_sparse();
        logic [8:0] tbl [3];
        rec_t       x, o;
        bit         tmo;
        tbl[0] = {8'h6B, 1'b0};
        tbl[1] = {8'h00, 1'b1};
        tbl[2] = {8'h00, 1'b0};
        for (int k = 0; k < 3; k++) begin
            send_odd_sparse(tbl[k][8:1], tbl[k][0]);
            fetch(1'b1, x, o, tmo);
            n_checks++; if (o.data !== x.data) begin n_fail++; $display("FAIL odd_data[%0d]: got %h want %h", k, o.data, x.data); end
            n_checks++; if (o.perr !== x.perr) begin n_fail++; $display("FAIL odd_perr[%0d]: got %b want %b", k, o.perr, x.perr); end
            n_checks++; if (o.cyc !== x.cyc)   begin n_fail++; $display("FAIL odd_latency[%0d]: got cycle %0d want %0d", k, o.cyc, x.cyc); end
        end
    endtask

    task automatic test_back_to_back();
        rec_t x1, o1, x2, o2;
        bit   t1, t2;
        send_e(8'hFF, 1'b0, 1'b1);
        send_e(8'h01, 1'b1, 1'b1);
        rx_e = 1'b1;
        fetch(1'b0, x1, o1, t1);
        fetch(1'b0, x2, o2, t2);
        n_checks++; if (o1.data !== 8'hFF) begin n_fail++; $display("FAIL b2b_data0: got %h want ff", o1.data); end
        n_checks++; if (o2.data !== 8'h01) begin n_fail++; $display("FAIL b2b_data1: got %h want 01", o2.data); end
        n_checks++; if ({o1.perr, o2.perr} !== {x1.perr, x2.perr}) begin n_fail++; $display("FAIL b2b_perr: got %b%b want %b%b", o1.perr, o2.perr, x1.perr, x2.perr); end
        n_checks++; if (o1.cyc !== x1.cyc) begin n_fail++; $display("FAIL b2b_latency0: got cycle %0d want %0d", o1.cyc, x1.cyc); end
        n_checks++; if (o2.cyc - o1.cyc != 11) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 11", o2.cyc - o1.cyc); end
    endtask

    initial begin
        test_reset();
        test_even_frame(1'b0);
        test_even_frame(1'b1);
        test_frame_err();
        test_reset_abort();
        test_odd_sparse();
        test_back_to_back();
        repeat (5) drive_e(1'b1, 1'b1);
        n_checks++; if (stray_perr != 0) begin n_fail++; $display("FAIL perr_without_valid: got %0d cycles want 0", stray_perr); end
        n_checks++; if (obs_e.size() != rd_e || obs_odd.size() != rd_odd) begin n_fail++; $display("FAIL unexpected_valid: got %0d/%0d extra want 0/0", obs_e.size() - rd_e, obs_odd.size() - rd_odd); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
